// File: rtl/cpu54_div_pkg.sv
// cpu54_div_pkg: shared state encoding, default width and counter sizing for the MIPS-54 divider.
package cpu54_div_pkg;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on the {rem, quo} shift pair.
module div_step
    import cpu54_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // One extra bit so the shifted remainder never overflows before the trial subtract.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer; stalls the CPU while a restoring divider
// produces one quotient bit per clock, then delivers HI/LO with a one-cycle done pulse.
module div_seq_ctrl
    import cpu54_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             accept;
    logic             dz_now;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign accept      = start && (state_q == S_IDLE || state_q == S_DONE);
    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign stall       = busy || accept;
    assign done        = state_q == S_DONE;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;
    assign dz_now      = dvs_q == '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;
        case (state_q)
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                quotient_d  = dz_now ? '1 : (q_neg_q ? -quo_q : quo_q);
                remainder_d = dz_now ? dvd_q : (r_neg_q ? -rem_q : rem_q);
                dz_d        = dz_now;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        // Most-negative magnitude fits as an unsigned WIDTH-bit value.
        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_d   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            dvd_d   = dividend;
            q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = is_signed && dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: scoreboard bench for the DIV/DIVU sequencer.
module tb_div_seq_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         stall, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk_in = ~clk_in;

    function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        if (b == '0) begin
            e.q  = {W{1'b1}};
            e.r  = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at a negedge; start is seen by exactly one rising edge.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        sb.push_back(model(s, a, b));
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int stall_cyc);
        cyc = 0;
        stall_cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (stall === 1'b1) stall_cyc++;
            cyc++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) @(negedge clk_in);
        checks++; if ({quotient, remainder} !== '0) $display("FAIL reset_results: got %h/%h want 0/0", quotient, remainder); else passed++;
        checks++; if ({done, busy, stall, div_by_zero} !== 4'b0) $display("FAIL reset_flags: got done=%b busy=%b stall=%b dz=%b want 0", done, busy, stall, div_by_zero); else passed++;
        reset = 1'b1;
        @(negedge clk_in);
        checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_divu_basic();
        int cyc, sc;
        exp_t e;
        issue(1'b0, 32'd100, 32'd7);
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if (cyc !== 33) $display("FAIL divu_latency: got %0d want 33", cyc); else passed++;
        checks++; if (sc !== 33) $display("FAIL divu_stall_cycles: got %0d want 33", sc); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL divu_stall_in_done: got %b want 0", stall); else passed++;
        checks++; if (quotient !== e.q || quotient !== 32'h0000_000E) $display("FAIL divu_q: got %h want %h", quotient, e.q); else passed++;
        checks++; if (remainder !== e.r || remainder !== 32'h0000_0002) $display("FAIL divu_r: got %h want %h", remainder, e.r); else passed++;
        checks++; if (div_by_zero !== e.dz) $display("FAIL divu_dz: got %b want %b", div_by_zero, e.dz); else passed++;
        @(negedge clk_in);
        checks++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else passed++;
    endtask

    task automatic test_signed();
        int cyc, sc;
        exp_t e;
        logic [W-1:0] a_tab [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] b_tab [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bit           s_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] q_tab [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0};
        logic [W-1:0] r_tab [4] = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h8000_0000};
        for (int i = 0; i < 4; i++) begin
            issue(s_tab[i], a_tab[i], b_tab[i]);
            wait_done(cyc, sc);
            e = sb.pop_front();
            checks++; if (quotient !== e.q || quotient !== q_tab[i]) $display("FAIL signed_q[%0d]: got %h want %h", i, quotient, q_tab[i]); else passed++;
            checks++; if (remainder !== e.r || remainder !== r_tab[i]) $display("FAIL signed_r[%0d]: got %h want %h", i, remainder, r_tab[i]); else passed++;
            checks++; if (div_by_zero !== 1'b0) $display("FAIL signed_dz[%0d]: got %b want 0", i, div_by_zero); else passed++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_div_zero();
        int cyc, sc;
        exp_t e;
        issue(1'b0, 32'h1234_5678, 32'h0);
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if (cyc !== 33) $display("FAIL dz_latency: got %0d want 33", cyc); else passed++;
        checks++; if (quotient !== e.q) $display("FAIL dz_q: got %h want %h", quotient, e.q); else passed++;
        checks++; if (remainder !== e.r) $display("FAIL dz_r: got %h want %h", remainder, e.r); else passed++;
        checks++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag: got %b want 1", div_by_zero); else passed++;
        @(negedge clk_in);
        issue(1'b1, 32'hFFFF_FF00, 32'h0);
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) $display("FAIL dz_signed: got %h/%h/%b want %h/%h/%b", quotient, remainder, div_by_zero, e.q, e.r, e.dz); else passed++;
        @(negedge clk_in);
    endtask

    task automatic test_ignore_start();
        int cyc, sc;
        exp_t e;
        issue(1'b0, 32'd1000, 32'd9);
        repeat (9) @(negedge clk_in);
        dividend  = 32'd55;
        divisor   = 32'd5;
        start     = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if (cyc + 10 !== 33) $display("FAIL ignore_latency: got %0d want 33", cyc + 10); else passed++;
        checks++; if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL ignore_result: got %h/%h want %h/%h", quotient, remainder, e.q, e.r); else passed++;
        repeat (5) @(negedge clk_in);
        checks++; if ({done, busy} !== 2'b00) $display("FAIL ignore_no_second_op: got done=%b busy=%b want 0", done, busy); else passed++;
        checks++; if (quotient !== e.q) $display("FAIL result_held: got %h want %h", quotient, e.q); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc, sc;
        exp_t e;
        issue(1'b1, 32'hFFFF_FF9C, 32'd3);
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL b2b_first: got %h/%h want %h/%h", quotient, remainder, e.q, e.r); else passed++;
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        checks++; if (busy !== 1'b1) $display("FAIL b2b_no_bubble: got busy=%b want 1", busy); else passed++;
        repeat (5) @(negedge clk_in);
        checks++; if (quotient !== e.q) $display("FAIL b2b_held_midop: got %h want %h", quotient, e.q); else passed++;
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if (cyc + 5 !== 33) $display("FAIL b2b_latency: got %0d want 33", cyc + 5); else passed++;
        checks++; if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL b2b_second: got %h/%h want %h/%h", quotient, remainder, e.q, e.r); else passed++;
        @(negedge clk_in);
    endtask

    task automatic test_random();
        int cyc, sc;
        exp_t e;
        logic [W-1:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 300)) : $urandom;
            if (i == 3) b = 32'hFFFF_FFF0;
            issue(1'($urandom_range(0, 1)), a, b);
            wait_done(cyc, sc);
            e = sb.pop_front();
            checks++; if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dz}) $display("FAIL random[%0d] a=%h b=%h s=%b: got %h/%h want %h/%h", i, a, b, is_signed, quotient, remainder, e.q, e.r); else passed++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, sc, dones;
        exp_t e;
        issue(1'b0, 32'hFFFF_0000, 32'd77);
        void'(sb.pop_back());
        repeat (14) @(negedge clk_in);
        reset = 1'b0;
        #1;
        checks++; if ({quotient, remainder, div_by_zero} !== '0) $display("FAIL abort_outputs: got %h/%h/%b want 0", quotient, remainder, div_by_zero); else passed++;
        checks++; if ({busy, done, stall} !== 3'b000) $display("FAIL abort_flags: got busy=%b done=%b stall=%b want 0", busy, done, stall); else passed++;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dones); else passed++;
        issue(1'b0, 32'd9, 32'd3);
        wait_done(cyc, sc);
        e = sb.pop_front();
        checks++; if ({quotient, remainder} !== {e.q, e.r} || quotient !== 32'd3) $display("FAIL abort_fresh: got %h/%h want %h/%h", quotient, remainder, e.q, e.r); else passed++;
        checks++; if (cyc !== 33) $display("FAIL abort_fresh_latency: got %0d want 33", cyc); else passed++;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_abort();
        checks++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU instructions of the single-cycle MIPS-54 CPU.
- Accepts operands from the decode/ALU stage and runs an iterative restoring divider, one quotient bit per clock.
- Asserts stall so the PC register and register-file writes freeze.
- Delivers quotient/remainder to the HI/LO registers with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width in bits (WIDTH >= 4).

Ports:
clk_in  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  request a divide; sampled on rising edge.
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
dividend  input  WIDTH  operand; sampled with start.
divisor  input  WIDTH  operand; sampled with start.
stall  output  1  combinational: busy | (start & state accepts start); holds PC/regfile.
busy  output  1  high in CALC and FIX.
done  output  1  one-cycle pulse in DONE state; quotient/remainder valid.
quotient  output  WIDTH  to LO; held until next completion.
remainder  output  WIDTH  to HI; held until next completion.
div_by_zero  output  1  registered with results; 1 if divisor was 0.

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (reset=0, asynchronous) forces:
  - state IDLE, step counter 0, all internal registers 0;
  - quotient=0, remainder=0, done=0, busy=0, div_by_zero=0.
- IDLE/DONE with start=1 on edge E0:
  - latch magnitudes |dividend|, |divisor| (magnitudes only when is_signed=1; otherwise raw);
  - latch sign flags q_neg = sign(dividend) ^ sign(divisor) and r_neg = sign(dividend), both only when is_signed;
  - clear partial remainder; go to CALC with count=0.
- start in CALC or FIX is ignored; no queueing.
- CALC: each edge shifts {rem, quo} left by 1 and subtracts the divisor magnitude. On a non-negative result keep it and set the quotient LSB to 1; otherwise restore.
  - count increments each edge; after WIDTH steps (edges E1..E_WIDTH) go to FIX.
- FIX (edge E_WIDTH+1):
  - negate quotient if q_neg and remainder if r_neg;
  - register quotient, remainder and div_by_zero; go to DONE.
- DONE: done=1 for exactly one cycle. Next edge goes to IDLE, or to CALC if start=1 (back-to-back, no bubble).
- Latency: done high in the cycle after edge E0+WIDTH+1 (33 cycles for WIDTH=32). stall is high from the start cycle through FIX and low in DONE.
- Divisor = 0: normal timing. Result forced to quotient = all ones and remainder = original dividend, regardless of is_signed; div_by_zero=1.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, no flag.
- Magnitude of the most-negative value is treated as an unsigned WIDTH-bit value, so no extra bit is needed.
- Remainder sign always follows the dividend, and |remainder| < |divisor|.
- Reset asserted mid-CALC aborts immediately. After release: IDLE with outputs 0; done never pulses for the aborted operation.
- Outputs change only on the FIX edge or on reset.

Decomposition:
- Shared package cpu54_div_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3;
  - default WIDTH;
  - counter width constant CNT_W = clog2(WIDTH)+1.
- One natural sub-module, div_step: combinational single restoring step. Inputs: rem, quo, divisor magnitude. Outputs: next rem, next quo.
- The FSM, sign handling and output registers stay in div_seq_ctrl.

Test Plan:
- DIVU 100 / 7, start one cycle → stall high 33 cycles; done at cycle 33; quotient=0000000E, remainder=00000002, div_by_zero=0.
- DIV -7 / 2 → quotient=FFFFFFFD, remainder=FFFFFFFF. Then DIV 7 / -2 → quotient=FFFFFFFD, remainder=00000001.
- DIV 80000000 / FFFFFFFF → quotient=80000000, remainder=00000000, no flag. DIVU same operands → quotient=00000000, remainder=80000000.
- DIVU 12345678 / 0 → quotient=FFFFFFFF, remainder=12345678, div_by_zero=1, done at cycle 33.
- start pulsed again at cycle 10 of a busy operation with different operands → ignored, first result unchanged. start held during DONE → new operation begins with no idle cycle; second done 33 cycles later.
- reset driven low at cycle 15 of a divide, released 2 cycles later → all outputs 0, state IDLE, no done pulse; a fresh DIVU 9 / 3 then returns 3 r 0.
